conv_phase_centers_ctrl: RTL and testbench
==========================================

Name: conv_phase_centers_ctrl

Overview:
- Command sequencer for the channelizer's per-channel phase-center table.
- Decodes toggle-strobed commands from the 32-bit software register output (user_data_out of the conv_phase_centers register). Drives writes into the inactive (shadow) bank of a double-buffered phase-center RAM.
- Swaps banks atomically on an FFT frame boundary.
- Reports progress through a 32-bit status word for a readback register.

Parameters:
- ADDR_W, 8, channel address width (table depth 2^ADDR_W, max 13)
- DATA_W, 16, phase-center value width (max 16)

Ports:
- user_clk  in  1  datapath clock, all logic on rising edge
- user_rst_n  in  1  asynchronous active-low reset
- reg_data  in  32  software command word: [31] toggle strobe, [30:29] opcode (00 WRITE, 01 COMMIT, 10 CLEAR, 11 NOP), [16+ADDR_W-1:16] channel, [DATA_W-1:0] value
- frame_sync  in  1  one-cycle pulse at channel 0 of each FFT frame
- tbl_we  out  1  table write enable
- tbl_addr  out  ADDR_W+1  {bank, channel}; bank is always ~active_bank
- tbl_data  out  DATA_W  table write data
- active_bank  out  1  bank read by the datapath
- status  out  32  [31] busy, [30] swap_pending, [29] active_bank, [28] primed, [27:16] 0, [15:0] write_count

Behaviour:
- Reset (async assert, sync release):
  - tbl_we=0, tbl_addr=0, tbl_data=0, active_bank=0, status=0.
  - State IDLE; last_tog=0; primed=0.
- Input capture: reg_data is registered into d1, then into d2 every cycle.
- Priming: on the first cycle after reset release, last_tog<=d2[31] and primed<=1. No command executes, so a stale toggle in the register never fires after reset.
- Acceptance: a command is accepted only when all of the following hold:
  - primed=1
  - state=IDLE
  - d2[31]!=last_tog
  - d1==d2 (word stable for 2 cycles)
- On acceptance, last_tog<=d2[31]. Commands seen while busy are not consumed; they remain pending and are accepted on return to IDLE.
- Latency: a write command that changes reg_data at cycle 0 gives tbl_we=1 during cycle 3 (d1 at 1, d2 at 2, accept at 2, drive at 3).
- FSM states: IDLE, WRITE, CLEAR, SWAP_WAIT.
- IDLE:
  - WRITE goes to state WRITE.
  - COMMIT sets swap_pending=1 and goes to SWAP_WAIT.
  - CLEAR loads clr_addr=0 and goes to CLEAR.
  - NOP stays in IDLE.
  - frame_sync is ignored.
- WRITE (1 cycle):
  - tbl_we=1, tbl_addr={~active_bank, channel}, tbl_data=value.
  - write_count increments, saturating at 0xFFFF.
  - Returns to IDLE.
- CLEAR:
  - One write per cycle: tbl_we=1, tbl_addr={~active_bank, clr_addr}, tbl_data=0, clr_addr++.
  - After address 2^ADDR_W-1 (exactly 2^ADDR_W cycles), goes to IDLE and write_count<=0.
  - frame_sync is ignored.
- SWAP_WAIT:
  - On a cycle with frame_sync=1: active_bank toggles at that edge, swap_pending<=0, write_count<=0, then IDLE.
  - A frame_sync coincident with the COMMIT acceptance cycle does not count; the swap uses the next pulse.
- Outputs:
  - tbl_we is 0 in IDLE and SWAP_WAIT.
  - tbl_addr and tbl_data hold their last values when tbl_we=0.
- busy is 1 whenever state!=IDLE.
- Reset mid-CLEAR or mid-SWAP_WAIT aborts the operation: the shadow bank may be partially cleared and active_bank returns to 0. Software must reissue.
- Opcode is decoded from d2. Bits outside the defined fields are ignored.

Test Plan:
- Reset release with reg_data=0x8000_0000 -> no tbl_we for 20 cycles; status=0x1000_0000 (primed only).
- From primed, reg_data=0x8005_1234 (WRITE ch5, value 0x1234) -> tbl_we=1 exactly once, 3 cycles later, with tbl_addr=0x105 and tbl_data=0x1234; status[15:0]=1.
- COMMIT via reg_data=0x2000_0000 after 3 writes, frame_sync every 256 cycles -> status[31:30]=11 until the next frame_sync, then active_bank=1, write_count=0, busy=0. A subsequent WRITE to ch7 gives tbl_addr=0x007.
- CLEAR via reg_data=0xC000_0000 with ADDR_W=8 -> 256 consecutive tbl_we cycles covering addresses 0x100..0x1FF with data 0, busy=1 throughout. A WRITE toggled mid-sweep executes only after the sweep ends.
- COMMIT accepted in the same cycle as frame_sync -> active_bank is unchanged on that pulse and toggles on the following pulse.
- Assert user_rst_n=0 at sweep index 40 of a CLEAR -> all outputs go to 0 immediately (asynchronously). After release, no command fires until reg_data[31] toggles again.

Source files
------------

// File: rtl/conv_phase_centers_ctrl.sv
// rtl/conv_phase_centers_ctrl.sv - phase-center table command sequencer
// Decodes toggle-strobed register commands into shadow-bank writes and frame-aligned bank swaps.
module conv_phase_centers_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       reg_data,
  input  logic              frame_sync,
  output logic              tbl_we,
  output logic [ADDR_W:0]   tbl_addr,
  output logic [DATA_W-1:0] tbl_data,
  output logic              active_bank,
  output logic [31:0]       status
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_CLEAR,
    S_SWAP_WAIT
  } state_t;

  localparam logic [1:0]        OP_WRITE  = 2'b00;
  localparam logic [1:0]        OP_COMMIT = 2'b01;
  localparam logic [1:0]        OP_CLEAR  = 2'b10;
  localparam logic [ADDR_W-1:0] CLR_LAST  = '1;
  localparam logic [15:0]       WC_MAX    = 16'hFFFF;

  state_t              state_q, state_d;
  logic [31:0]         d1_q, d2_q;
  logic                last_tog_q, last_tog_d;
  logic                primed_q, primed_d;
  logic                swap_pending_q, swap_pending_d;
  logic                active_bank_q, active_bank_d;
  logic [15:0]         write_count_q, write_count_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                tbl_we_q, tbl_we_d;
  logic [ADDR_W:0]     tbl_addr_q, tbl_addr_d;
  logic [DATA_W-1:0]   tbl_data_q, tbl_data_d;

  logic [1:0]          cmd_op;
  logic [ADDR_W-1:0]   cmd_ch;
  logic [DATA_W-1:0]   cmd_val;
  logic [ADDR_W-1:0]   clr_next;
  logic                accept;

  // The capture pipeline keeps sampling through reset so that priming sees the
  // word software left behind, not a reset value that would look like a toggle.
  always_ff @(posedge user_clk) begin
    d1_q <= reg_data;
    d2_q <= d1_q;
  end

  always_comb begin
    cmd_op   = d2_q[30:29];
    cmd_ch   = d2_q[16 +: ADDR_W];
    cmd_val  = d2_q[DATA_W-1:0];
    clr_next = clr_addr_q + 1'b1;
    accept   = primed_q && (state_q == S_IDLE) && (d2_q[31] != last_tog_q) && (d1_q == d2_q);

    state_d        = state_q;
    last_tog_d     = last_tog_q;
    primed_d       = primed_q;
    swap_pending_d = swap_pending_q;
    active_bank_d  = active_bank_q;
    write_count_d  = write_count_q;
    clr_addr_d     = clr_addr_q;
    tbl_we_d       = 1'b0;
    tbl_addr_d     = tbl_addr_q;
    tbl_data_d     = tbl_data_q;

    if (!primed_q) begin
      primed_d   = 1'b1;
      last_tog_d = d2_q[31];
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          last_tog_d = d2_q[31];
          case (cmd_op)
            OP_WRITE: begin
              state_d       = S_WRITE;
              tbl_we_d      = 1'b1;
              tbl_addr_d    = {~active_bank_q, cmd_ch};
              tbl_data_d    = cmd_val;
              write_count_d = (write_count_q == WC_MAX) ? write_count_q : write_count_q + 16'd1;
            end
            OP_COMMIT: begin
              state_d        = S_SWAP_WAIT;
              swap_pending_d = 1'b1;
            end
            OP_CLEAR: begin
              state_d    = S_CLEAR;
              clr_addr_d = '0;
              tbl_we_d   = 1'b1;
              tbl_addr_d = {~active_bank_q, {ADDR_W{1'b0}}};
              tbl_data_d = '0;
            end
            default: ;
          endcase
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        // clr_addr_q is the address being driven this cycle
        if (clr_addr_q == CLR_LAST) begin
          state_d       = S_IDLE;
          write_count_d = '0;
        end else begin
          clr_addr_d = clr_next;
          tbl_we_d   = 1'b1;
          tbl_addr_d = {~active_bank_q, clr_next};
          tbl_data_d = '0;
        end
      end
      S_SWAP_WAIT: begin
        if (frame_sync) begin
          state_d        = S_IDLE;
          active_bank_d  = ~active_bank_q;
          swap_pending_d = 1'b0;
          write_count_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q        <= S_IDLE;
      last_tog_q     <= 1'b0;
      primed_q       <= 1'b0;
      swap_pending_q <= 1'b0;
      active_bank_q  <= 1'b0;
      write_count_q  <= '0;
      clr_addr_q     <= '0;
      tbl_we_q       <= 1'b0;
      tbl_addr_q     <= '0;
      tbl_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      last_tog_q     <= last_tog_d;
      primed_q       <= primed_d;
      swap_pending_q <= swap_pending_d;
      active_bank_q  <= active_bank_d;
      write_count_q  <= write_count_d;
      clr_addr_q     <= clr_addr_d;
      tbl_we_q       <= tbl_we_d;
      tbl_addr_q     <= tbl_addr_d;
      tbl_data_q     <= tbl_data_d;
    end
  end

  assign tbl_we      = tbl_we_q;
  assign tbl_addr    = tbl_addr_q;
  assign tbl_data    = tbl_data_q;
  assign active_bank = active_bank_q;
  assign status      = {(state_q != S_IDLE), swap_pending_q, active_bank_q, primed_q, 12'd0, write_count_q};

endmodule

// File: tb/tb_conv_phase_centers_ctrl.sv
// tb/tb_conv_phase_centers_ctrl.sv - bench for conv_phase_centers_ctrl
// Directed scenarios plus a randomized command stream against a table-write model.
module tb_conv_phase_centers_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_COMMIT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  logic              user_clk = 1'b0;
  logic              user_rst_n = 1'b0;
  logic [31:0]       reg_data = '0;
  logic              frame_sync = 1'b0;
  logic              tbl_we;
  logic [ADDR_W:0]   tbl_addr;
  logic [DATA_W-1:0] tbl_data;
  logic              active_bank;
  logic [31:0]       status;

  int   errors = 0;
  int   checks = 0;
  logic tog = 1'b0;
  bit   auto_fs = 1'b0;
  int   fs_cnt = 0;
  logic exp_ab = 1'b0;
  logic [15:0] exp_wc = '0;
  logic [ADDR_W+DATA_W:0] act_q[$];
  logic [ADDR_W+DATA_W:0] exp_q[$];

  conv_phase_centers_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .user_clk    (user_clk),
    .user_rst_n  (user_rst_n),
    .reg_data    (reg_data),
    .frame_sync  (frame_sync),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_data    (tbl_data),
    .active_bank (active_bank),
    .status      (status)
  );

  always #5 user_clk = ~user_clk;

  always @(negedge user_clk) begin
    if (tbl_we === 1'b1) act_q.push_back({tbl_addr, tbl_data});
  end

  initial begin
    forever begin
      @(posedge user_clk);
      #1;
      if (auto_fs) begin
        fs_cnt++;
        frame_sync = (fs_cnt % 256 == 0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] ch,
                          input logic [DATA_W-1:0] val, input bit add_junk);
    logic [31:0] w;
    w = '0;
    tog = ~tog;
    w[31] = tog;
    w[30:29] = op;
    w[16 +: ADDR_W] = ch;
    w[DATA_W-1:0] = val;
    if (add_junk)
      for (int b = 16 + ADDR_W; b < 29; b++) w[b] = 1'($urandom_range(0, 1));
    reg_data = w;
  endtask

  task automatic wait_we(input int bound, output bit got);
    got = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge user_clk);
      if (tbl_we === 1'b1) begin
        got = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (status[31] === 1'b0) begin
        ok = 1'b1;
        return;
      end
      @(negedge user_clk);
    end
  endtask

  task automatic test_reset();
    int we_seen;
    reg_data = 32'h8000_0000;
    tog = 1'b1;
    user_rst_n = 1'b0;
    frame_sync = 1'b0;
    repeat (4) @(posedge user_clk);
    #1;
    checks++;
    if ({tbl_we, tbl_addr, tbl_data, active_bank} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b addr=%h data=%h bank=%b, required all 0", tbl_we, tbl_addr, tbl_data, active_bank);
    end
    checks++;
    if (status !== 32'h0) begin
      errors++;
      $display("FAIL reset_status: got %h required 00000000", status);
    end
    @(negedge user_clk);
    user_rst_n = 1'b1;
    we_seen = 0;
    repeat (20) begin
      @(negedge user_clk);
      if (tbl_we !== 1'b0) we_seen++;
    end
    checks++;
    if (we_seen != 0) begin
      errors++;
      $display("FAIL stale_toggle: tbl_we high %0d cycles, required 0", we_seen);
    end
    checks++;
    if (status !== 32'h1000_0000) begin
      errors++;
      $display("FAIL primed_status: got %h required 10000000", status);
    end
    exp_ab = 1'b0;
    exp_wc = '0;
  endtask

  task automatic test_write_latency();
    int first, cnt;
    logic [ADDR_W:0] a;
    logic [DATA_W-1:0] d;
    first = -1;
    cnt = 0;
    a = '0;
    d = '0;
    @(posedge user_clk);
    #1;
    send_cmd(OP_WRITE, 8'h05, 16'h1234, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge user_clk);
      if (tbl_we === 1'b1) begin
        if (first < 0) begin
          first = i;
          a = tbl_addr;
          d = tbl_data;
        end
        cnt++;
      end
    end
    exp_wc = 16'd1;
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL write_latency: first tbl_we at cycle %0d required 3", first);
    end
    checks++;
    if (cnt != 1) begin
      errors++;
      $display("FAIL write_once: tbl_we cycles %0d required 1", cnt);
    end
    checks++;
    if (a !== 9'h105 || d !== 16'h1234) begin
      errors++;
      $display("FAIL write_addr_data: addr=%h data=%h required 105/1234", a, d);
    end
    checks++;
    if (status[15:0] !== exp_wc) begin
      errors++;
      $display("FAIL write_count: got %0d required %0d", status[15:0], exp_wc);
    end
  endtask

  task automatic test_clear_pending_write();
    bit got;
    int bad;
    logic [ADDR_W-1:0] ai;
    @(posedge user_clk);
    #1;
    send_cmd(OP_CLEAR, '0, '0, 1'b0);
    wait_we(10, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL clear_start: no tbl_we within 10 cycles");
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ai = i[ADDR_W-1:0];
      if (tbl_we !== 1'b1 || tbl_addr !== {~exp_ab, ai} || tbl_data !== '0 || status[31] !== 1'b1) begin
        bad++;
        if (bad < 4)
          $display("FAIL clear_sweep[%0d]: we=%b addr=%h data=%h busy=%b required 1/%h/0/1",
                   i, tbl_we, tbl_addr, tbl_data, status[31], {~exp_ab, ai});
      end
      if (i == 50) send_cmd(OP_WRITE, 8'h33, 16'hBEEF, 1'b0);
      @(negedge user_clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_sweep: %0d bad sweep cycles, required 0", bad);
    end
    checks++;
    if (tbl_we !== 1'b0) begin
      errors++;
      $display("FAIL clear_end: tbl_we=%b after sweep, required 0", tbl_we);
    end
    wait_we(6, got);
    exp_wc = 16'd1;
    checks++;
    if (!got || tbl_addr !== {~exp_ab, 8'h33} || tbl_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL pending_write: got=%b addr=%h data=%h required 1/%h/beef", got, tbl_addr, tbl_data, {~exp_ab, 8'h33});
    end
    @(negedge user_clk);
    checks++;
    if (status[31] !== 1'b0 || status[15:0] !== exp_wc) begin
      errors++;
      $display("FAIL clear_count: busy=%b count=%0d required 0/%0d", status[31], status[15:0], exp_wc);
    end
  endtask

  task automatic test_commit();
    bit got, swapped;
    int viol;
    auto_fs = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge user_clk);
      #1;
      send_cmd(OP_WRITE, 8'($urandom), 16'($urandom), 1'b1);
      repeat (6) @(negedge user_clk);
      exp_wc++;
    end
    checks++;
    if (status[15:0] !== exp_wc) begin
      errors++;
      $display("FAIL commit_prewrites: count %0d required %0d", status[15:0], exp_wc);
    end
    @(posedge user_clk);
    #1;
    send_cmd(OP_COMMIT, '0, '0, 1'b0);
    repeat (3) @(negedge user_clk);
    swapped = 1'b0;
    viol = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge user_clk);
      if (active_bank !== exp_ab) begin
        swapped = 1'b1;
        break;
      end
      if (status[31:30] !== 2'b11) viol++;
    end
    checks++;
    if (!swapped || viol != 0) begin
      errors++;
      $display("FAIL commit_wait: swapped=%b busy/pending violations=%0d required 1/0", swapped, viol);
    end
    exp_ab = ~exp_ab;
    exp_wc = '0;
    checks++;
    if (status !== {3'b001 & {1'b0, 1'b0, exp_ab}, 1'b1, 12'd0, 16'd0}) begin
      errors++;
      $display("FAIL commit_status: got %h required %h", status, {1'b0, 1'b0, exp_ab, 1'b1, 28'd0});
    end
    @(posedge user_clk);
    #1;
    send_cmd(OP_WRITE, 8'h07, 16'($urandom), 1'b1);
    wait_we(8, got);
    exp_wc = 16'd1;
    checks++;
    if (!got || tbl_addr !== {~exp_ab, 8'h07}) begin
      errors++;
      $display("FAIL post_swap_write: got=%b addr=%h required 1/%h", got, tbl_addr, {~exp_ab, 8'h07});
    end
    auto_fs = 1'b0;
    frame_sync = 1'b0;
    repeat (4) @(negedge user_clk);
  endtask

  task automatic test_commit_coincident();
    frame_sync = 1'b0;
    @(posedge user_clk);
    #1;
    send_cmd(OP_COMMIT, '0, '0, 1'b1);
    @(posedge user_clk);
    #1;
    @(posedge user_clk);
    #1;
    frame_sync = 1'b1;
    @(posedge user_clk);
    #1;
    frame_sync = 1'b0;
    repeat (10) @(negedge user_clk);
    checks++;
    if (active_bank !== exp_ab || status[31:30] !== 2'b11) begin
      errors++;
      $display("FAIL coincident_ignored: bank=%b busy/pending=%b required %b/11", active_bank, status[31:30], exp_ab);
    end
    @(posedge user_clk);
    #1;
    frame_sync = 1'b1;
    @(posedge user_clk);
    #1;
    frame_sync = 1'b0;
    exp_ab = ~exp_ab;
    exp_wc = '0;
    @(negedge user_clk);
    checks++;
    if (active_bank !== exp_ab || status[31:30] !== 2'b00 || status[15:0] !== 16'd0) begin
      errors++;
      $display("FAIL coincident_next: bank=%b busy/pending=%b count=%0d required %b/00/0",
               active_bank, status[31:30], status[15:0], exp_ab);
    end
  endtask

  task automatic test_random_stream();
    int r;
    bit ok;
    logic [1:0] op;
    logic [ADDR_W-1:0] ch, ai;
    logic [DATA_W-1:0] val;
    act_q.delete();
    exp_q.delete();
    auto_fs = 1'b1;
    fs_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      ch = ADDR_W'($urandom);
      val = DATA_W'($urandom);
      if (r < 70) begin
        op = OP_WRITE;
        exp_q.push_back({~exp_ab, ch, val});
        if (exp_wc != 16'hFFFF) exp_wc++;
      end else if (r < 78) begin
        op = OP_CLEAR;
        for (int i = 0; i < DEPTH; i++) begin
          ai = i[ADDR_W-1:0];
          exp_q.push_back({~exp_ab, ai, {DATA_W{1'b0}}});
        end
        exp_wc = '0;
      end else if (r < 90) begin
        op = OP_COMMIT;
        exp_ab = ~exp_ab;
        exp_wc = '0;
      end else begin
        op = OP_NOP;
      end
      @(posedge user_clk);
      #1;
      send_cmd(op, ch, val, 1'b1);
      repeat (4) @(negedge user_clk);
      wait_idle(700, ok);
      checks++;
      if (!ok || status[29] !== exp_ab || active_bank !== exp_ab || status[15:0] !== exp_wc) begin
        errors++;
        $display("FAIL random_status[%0d]: idle=%b bank=%b count=%0d required 1/%b/%0d",
                 n, ok, active_bank, status[15:0], exp_ab, exp_wc);
      end
    end
    auto_fs = 1'b0;
    frame_sync = 1'b0;
    repeat (2) @(negedge user_clk);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_write_count: %0d writes observed, required %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_write[%0d]: got addr/data %h required %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    bit got;
    int we_seen;
    frame_sync = 1'b0;
    if (exp_ab == 1'b0) begin
      @(posedge user_clk);
      #1;
      send_cmd(OP_COMMIT, '0, '0, 1'b0);
      repeat (6) @(posedge user_clk);
      #1;
      frame_sync = 1'b1;
      @(posedge user_clk);
      #1;
      frame_sync = 1'b0;
      exp_ab = 1'b1;
      exp_wc = '0;
    end
    @(posedge user_clk);
    #1;
    send_cmd(OP_CLEAR, '0, '0, 1'b0);
    wait_we(10, got);
    repeat (40) @(negedge user_clk);
    checks++;
    if (!got || tbl_addr !== {~exp_ab, 8'd40} || active_bank !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_sweep: got=%b addr=%h bank=%b required 1/%h/1", got, tbl_addr, active_bank, {~exp_ab, 8'd40});
    end
    user_rst_n = 1'b0;
    #1;
    checks++;
    if ({tbl_we, tbl_addr, tbl_data, active_bank} !== '0 || status !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: we=%b addr=%h data=%h bank=%b status=%h required all 0",
               tbl_we, tbl_addr, tbl_data, active_bank, status);
    end
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    user_rst_n = 1'b1;
    exp_ab = 1'b0;
    exp_wc = '0;
    we_seen = 0;
    repeat (30) begin
      @(negedge user_clk);
      if (tbl_we !== 1'b0) we_seen++;
    end
    checks++;
    if (we_seen != 0 || status !== 32'h1000_0000) begin
      errors++;
      $display("FAIL rereset_quiet: tbl_we cycles=%0d status=%h required 0/10000000", we_seen, status);
    end
    @(posedge user_clk);
    #1;
    send_cmd(OP_WRITE, 8'h42, 16'h5A5A, 1'b0);
    wait_we(8, got);
    checks++;
    if (!got || tbl_addr !== 9'h142 || tbl_data !== 16'h5A5A) begin
      errors++;
      $display("FAIL rereset_write: got=%b addr=%h data=%h required 1/142/5a5a", got, tbl_addr, tbl_data);
    end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_clear_pending_write();
    test_commit();
    test_commit_coincident();
    test_random_stream();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
